// File: rtl/npc_ctrl_pkg.sv
// Shared encodings and helpers for the NPC execution sequencer.
package npc_ctrl_pkg;

    localparam int unsigned STATE_W            = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1023;
    localparam int unsigned DEF_TO_W           = 10;
    localparam int unsigned DEF_CNT_W          = 64;

    typedef enum logic [STATE_W-1:0] {
        ST_RST    = 4'd0,
        ST_F_REQ  = 4'd1,
        ST_F_WAIT = 4'd2,
        ST_DEC    = 4'd3,
        ST_M_REQ  = 4'd4,
        ST_M_WAIT = 4'd5,
        ST_WB     = 4'd6,
        ST_HALT   = 4'd7,
        ST_ERR    = 4'd8
    } state_e;

    // Registered control outputs of the sequencer, one bit per port.
    typedef struct packed {
        logic ifu_req_valid;
        logic ifu_resp_ready;
        logic lsu_req_valid;
        logic lsu_resp_ready;
        logic pc_wen;
        logic r_wen;
        logic csr_wen1;
        logic csr_wen2;
        logic busy;
        logic halted;
        logic bus_err;
    } seq_out_t;

    function automatic logic is_bus_wait(input state_e s);
        return s inside {ST_F_REQ, ST_F_WAIT, ST_M_REQ, ST_M_WAIT};
    endfunction

    function automatic logic is_busy(input state_e s);
        return !(s inside {ST_RST, ST_HALT, ST_ERR});
    endfunction

endpackage

// File: rtl/npc_bus_wdog.sv
// Bus wait watchdog: counts cycles spent in the current wait state and flags expiry.
module npc_bus_wdog #(
    parameter int unsigned TO_W           = 10,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    logic [TO_W-1:0] cnt_q;

    // cnt_q holds cycles already spent, so the current cycle is number cnt_q+1.
    assign expired_c = en && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en && !expired_c) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

endmodule

// File: rtl/npc_exec_seq.sv
// Multi-cycle fetch/decode/mem/writeback sequencer for the NPC core,
// with bus handshakes, a wait-state watchdog and cycle/instret counters.
module npc_exec_seq
    import npc_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned TO_W           = DEF_TO_W,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    input  logic             ifu_resp_valid,
    input  logic             ifu_resp_err,
    output logic             ifu_resp_ready,
    output logic             inst_wen,
    input  logic             dec_mem_ren,
    input  logic             dec_mem_wen,
    input  logic             dec_r_wen,
    input  logic             dec_csr_wen1,
    input  logic             dec_csr_wen2,
    input  logic             dec_halt,
    output logic             lsu_req_valid,
    input  logic             lsu_req_ready,
    input  logic             lsu_resp_valid,
    input  logic             lsu_resp_err,
    output logic             lsu_resp_ready,
    output logic             pc_wen,
    output logic             r_wen,
    output logic             csr_wen1,
    output logic             csr_wen2,
    output logic             busy,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    state_e   state_q, state_d;
    seq_out_t out_q, out_d;
    logic     wdog_exp;

    npc_bus_wdog #(
        .TO_W           (TO_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state_d != state_q),
        .en        (is_bus_wait(state_q)),
        .expired_c (wdog_exp)
    );

    // Next state; a completing handshake is checked before the watchdog.
    always_comb begin
        state_d  = state_q;
        inst_wen = 1'b0;
        case (state_q)
            ST_RST:    state_d = ST_F_REQ;
            ST_F_REQ: begin
                if (ifu_req_ready)  state_d = ST_F_WAIT;
                else if (wdog_exp)  state_d = ST_ERR;
            end
            ST_F_WAIT: begin
                if (ifu_resp_valid) begin
                    if (ifu_resp_err) begin
                        state_d = ST_ERR;
                    end else begin
                        inst_wen = 1'b1;
                        state_d  = ST_DEC;
                    end
                end else if (wdog_exp) begin
                    state_d = ST_ERR;
                end
            end
            ST_DEC: begin
                if (dec_halt)                        state_d = ST_HALT;
                else if (dec_mem_ren || dec_mem_wen) state_d = ST_M_REQ;
                else                                 state_d = ST_WB;
            end
            ST_M_REQ: begin
                if (lsu_req_ready)  state_d = ST_M_WAIT;
                else if (wdog_exp)  state_d = ST_ERR;
            end
            ST_M_WAIT: begin
                if (lsu_resp_valid)  state_d = lsu_resp_err ? ST_ERR : ST_WB;
                else if (wdog_exp)   state_d = ST_ERR;
            end
            ST_WB:     state_d = ST_F_REQ;
            ST_HALT:   state_d = ST_HALT;
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_ERR;
        endcase
    end

    // Moore outputs precomputed from the next state so they leave flops.
    always_comb begin
        out_d         = '0;
        out_d.busy    = is_busy(state_d);
        out_d.halted  = (state_d == ST_HALT);
        out_d.bus_err = (state_d == ST_ERR);
        case (state_d)
            ST_F_REQ:  out_d.ifu_req_valid  = 1'b1;
            ST_F_WAIT: out_d.ifu_resp_ready = 1'b1;
            ST_M_REQ:  out_d.lsu_req_valid  = 1'b1;
            ST_M_WAIT: out_d.lsu_resp_ready = 1'b1;
            ST_WB: begin
                out_d.pc_wen   = 1'b1;
                out_d.r_wen    = dec_r_wen;
                out_d.csr_wen1 = dec_csr_wen1;
                out_d.csr_wen2 = dec_csr_wen2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RST;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
        end
    end

    // Performance counters; both wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (is_busy(state_q)) cycle_cnt   <= cycle_cnt + CNT_W'(1);
            if (state_q == ST_WB) instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end

    assign ifu_req_valid  = out_q.ifu_req_valid;
    assign ifu_resp_ready = out_q.ifu_resp_ready;
    assign lsu_req_valid  = out_q.lsu_req_valid;
    assign lsu_resp_ready = out_q.lsu_resp_ready;
    assign pc_wen         = out_q.pc_wen;
    assign r_wen          = out_q.r_wen;
    assign csr_wen1       = out_q.csr_wen1;
    assign csr_wen2       = out_q.csr_wen2;
    assign busy           = out_q.busy;
    assign halted         = out_q.halted;
    assign bus_err        = out_q.bus_err;

endmodule

// File: tb/tb_npc_exec_seq.sv
// Directed bench for npc_exec_seq: cycle-by-cycle output vectors and counter model.
module tb_npc_exec_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err, ifu_resp_ready, inst_wen;
    logic       dec_mem_ren, dec_mem_wen, dec_r_wen, dec_csr_wen1, dec_csr_wen2, dec_halt;
    logic       lsu_req_valid, lsu_req_ready, lsu_resp_valid, lsu_resp_err, lsu_resp_ready;
    logic       pc_wen, r_wen, csr_wen1, csr_wen2, busy, halted, bus_err;
    logic [3:0] cycle_cnt, instret_cnt;
    logic [11:0] outs;

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_cycle   = 4'd0;
    logic [3:0] exp_instret = 4'd0;

    // Output vector layout: [11] ifu_req_valid [10] ifu_resp_ready [9] inst_wen
    // [8] lsu_req_valid [7] lsu_resp_ready [6] pc_wen [5] r_wen [4] csr_wen1
    // [3] csr_wen2 [2] busy [1] halted [0] bus_err
    localparam logic [11:0] E_RST   = 12'h000;
    localparam logic [11:0] E_FREQ  = 12'h804;
    localparam logic [11:0] E_FWAIT = 12'h404;
    localparam logic [11:0] E_FW_IW = 12'h604;
    localparam logic [11:0] E_DEC   = 12'h004;
    localparam logic [11:0] E_MREQ  = 12'h104;
    localparam logic [11:0] E_MWAIT = 12'h084;
    localparam logic [11:0] E_WB    = 12'h044;
    localparam logic [11:0] E_WB_R  = 12'h064;
    localparam logic [11:0] E_WB_C  = 12'h05C;
    localparam logic [11:0] E_HALT  = 12'h002;
    localparam logic [11:0] E_ERR   = 12'h001;

    npc_exec_seq #(
        .TIMEOUT_CYCLES (8),
        .TO_W           (4),
        .CNT_W          (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_err   (ifu_resp_err),
        .ifu_resp_ready (ifu_resp_ready),
        .inst_wen       (inst_wen),
        .dec_mem_ren    (dec_mem_ren),
        .dec_mem_wen    (dec_mem_wen),
        .dec_r_wen      (dec_r_wen),
        .dec_csr_wen1   (dec_csr_wen1),
        .dec_csr_wen2   (dec_csr_wen2),
        .dec_halt       (dec_halt),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_err   (lsu_resp_err),
        .lsu_resp_ready (lsu_resp_ready),
        .pc_wen         (pc_wen),
        .r_wen          (r_wen),
        .csr_wen1       (csr_wen1),
        .csr_wen2       (csr_wen2),
        .busy           (busy),
        .halted         (halted),
        .bus_err        (bus_err),
        .cycle_cnt      (cycle_cnt),
        .instret_cnt    (instret_cnt)
    );

    always #5 clk = ~clk;

    assign outs = {ifu_req_valid, ifu_resp_ready, inst_wen, lsu_req_valid, lsu_resp_ready,
                   pc_wen, r_wen, csr_wen1, csr_wen2, busy, halted, bus_err};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven for this cycle.
    task automatic cyc(input string tag, input logic [11:0] exp);
        #1;
        chk({tag, "/out"}, 64'(outs), 64'(exp));
        chk({tag, "/cyc"}, 64'(cycle_cnt), 64'(exp_cycle));
        chk({tag, "/ret"}, 64'(instret_cnt), 64'(exp_instret));
        if (exp[2]) exp_cycle   = exp_cycle + 4'd1;
        if (exp[6]) exp_instret = exp_instret + 4'd1;
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        rst_n       = 1'b0;
        exp_cycle   = 4'd0;
        exp_instret = 4'd0;
        cyc({tag, "_a"}, E_RST);
        cyc({tag, "_b"}, E_RST);
        rst_n = 1'b1;
        cyc({tag, "_st"}, E_RST);
    endtask

    task automatic set_dec(input logic ren, input logic wen, input logic rw,
                           input logic c1, input logic c2, input logic hlt);
        dec_mem_ren  = ren;
        dec_mem_wen  = wen;
        dec_r_wen    = rw;
        dec_csr_wen1 = c1;
        dec_csr_wen2 = c2;
        dec_halt     = hlt;
    endtask

    task automatic fetch_dec(input string tag);
        cyc({tag, "_freq"}, E_FREQ);
        cyc({tag, "_fwait"}, E_FW_IW);
        cyc({tag, "_dec"}, E_DEC);
    endtask

    initial begin
        rst_n          = 1'b0;
        ifu_req_ready  = 1'b0;
        ifu_resp_valid = 1'b0;
        ifu_resp_err   = 1'b0;
        lsu_req_ready  = 1'b0;
        lsu_resp_valid = 1'b0;
        lsu_resp_err   = 1'b0;
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        // Reset held three cycles, then RST for one cycle, then F_REQ held.
        cyc("rst0", E_RST);
        cyc("rst1", E_RST);
        cyc("rst2", E_RST);
        rst_n = 1'b1;
        cyc("rst_st", E_RST);
        cyc("freq_stall0", E_FREQ);
        cyc("freq_stall1", E_FREQ);

        // addi with zero-wait buses; response already valid during F_REQ.
        ifu_req_ready  = 1'b1;
        ifu_resp_valid = 1'b1;
        set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        fetch_dec("addi");
        cyc("addi_wb", E_WB_R);

        // CSR instruction: both CSR ports, no GPR write.
        set_dec(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        fetch_dec("csr");
        cyc("csr_wb", E_WB_C);

        // lw: request accepted on 3rd M_REQ cycle, response on 3rd M_WAIT cycle.
        set_dec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        fetch_dec("lw");
        lsu_resp_valid = 1'b1;
        cyc("lw_mreq0", E_MREQ);
        lsu_resp_valid = 1'b0;
        cyc("lw_mreq1", E_MREQ);
        lsu_req_ready = 1'b1;
        cyc("lw_mreq2", E_MREQ);
        lsu_req_ready = 1'b0;
        cyc("lw_mwait0", E_MWAIT);
        cyc("lw_mwait1", E_MWAIT);
        lsu_resp_valid = 1'b1;
        cyc("lw_mwait2", E_MWAIT);
        lsu_resp_valid = 1'b0;
        cyc("lw_wb", E_WB_R);

        // sw with zero-wait LSU.
        set_dec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        lsu_req_ready  = 1'b1;
        lsu_resp_valid = 1'b1;
        fetch_dec("sw");
        cyc("sw_mreq", E_MREQ);
        cyc("sw_mwait", E_MWAIT);
        cyc("sw_wb", E_WB);

        // Response on the 8th M_WAIT cycle beats the watchdog.
        set_dec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        lsu_resp_valid = 1'b0;
        fetch_dec("edge");
        cyc("edge_mreq", E_MREQ);
        for (int i = 0; i < 7; i++) cyc($sformatf("edge_mwait%0d", i), E_MWAIT);
        lsu_resp_valid = 1'b1;
        cyc("edge_mwait7", E_MWAIT);
        lsu_resp_valid = 1'b0;
        cyc("edge_wb", E_WB_R);

        // No response: 8 cycles in M_WAIT, then ERR with counters frozen.
        fetch_dec("to");
        cyc("to_mreq", E_MREQ);
        for (int i = 0; i < 8; i++) cyc($sformatf("to_mwait%0d", i), E_MWAIT);
        for (int i = 0; i < 3; i++) cyc($sformatf("to_err%0d", i), E_ERR);

        // Fetch bus error: no inst_wen, then ERR.
        do_reset("rst_ferr");
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ifu_resp_err = 1'b1;
        cyc("ferr_freq", E_FREQ);
        cyc("ferr_fwait", E_FWAIT);
        cyc("ferr_err0", E_ERR);
        cyc("ferr_err1", E_ERR);
        ifu_resp_err = 1'b0;

        // ebreak with mem_ren: HALT wins, no LSU request, no retire.
        do_reset("rst_halt");
        set_dec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        fetch_dec("halt");
        for (int i = 0; i < 3; i++) cyc($sformatf("halt%0d", i), E_HALT);

        // Fetch request never accepted: ERR after 8 cycles in F_REQ.
        do_reset("rst_fto");
        set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ifu_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) cyc($sformatf("fto_freq%0d", i), E_FREQ);
        cyc("fto_err", E_ERR);

        // 20+ busy cycles wrap the 4-bit counters' model; then reset in M_WAIT.
        do_reset("rst_wrap");
        ifu_req_ready = 1'b1;
        set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            fetch_dec($sformatf("wrap%0d", k));
            cyc($sformatf("wrap%0d_wb", k), E_WB_R);
        end
        set_dec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        lsu_req_ready  = 1'b1;
        lsu_resp_valid = 1'b0;
        fetch_dec("mrst");
        cyc("mrst_mreq", E_MREQ);
        cyc("mrst_mwait0", E_MWAIT);
        cyc("mrst_mwait1", E_MWAIT);
        do_reset("mrst_rst");
        cyc("mrst_freq", E_FREQ);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
